// File: rtl/guardian_alert_arbiter.sv
`timescale 1ns/1ps
// guardian_alert_arbiter
// Buffers one pending alert per guardian source, serialises the alerts
// round-robin onto a single valid/ready stream, and holds a serviced source
// quiet for HOLDOFF cycles so that one noisy block cannot starve the others.
module guardian_alert_arbiter #(
   parameter int N_SRC   = 4,
   parameter int SCORE_W = 16,
   parameter int ID_W    = 16,
   parameter int HOLDOFF = 8,
   parameter int IDX_W   = $clog2(N_SRC)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [N_SRC-1:0]           alert_valid_in,
   input  logic [N_SRC*SCORE_W-1:0]   score_in,
   input  logic [N_SRC*ID_W-1:0]      block_id_in,
   output logic [N_SRC-1:0]           guardian_enable,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SCORE_W-1:0]         out_score,
   output logic [ID_W-1:0]            out_block_id,
   output logic [IDX_W-1:0]           out_src_idx,
   output logic [7:0]                 coalesce_cnt
);

   localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEL     = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [N_SRC-1:0]   pend_q, pend_d;
   logic [SCORE_W-1:0] score_q [N_SRC];
   logic [SCORE_W-1:0] score_d [N_SRC];
   logic [ID_W-1:0]    id_q    [N_SRC];
   logic [ID_W-1:0]    id_d    [N_SRC];
   logic [HO_W-1:0]    hold_q  [N_SRC];
   logic [HO_W-1:0]    hold_d  [N_SRC];
   logic [N_SRC-1:0]   ge_d;
   logic [IDX_W-1:0]   rr_ptr;
   logic [8:0]         events;
   logic [8:0]         cnt_sum;
   logic [SCORE_W-1:0] new_score;
   logic [IDX_W-1:0]   cand_idx;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_found;
   logic               load_out;
   logic               accept;

   // Per-source capture/merge and clear-on-accept; also counts merged and dropped alerts.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      pend_d    = pend_q;
      score_d   = score_q;
      id_d      = id_q;
      events    = '0;
      new_score = '0;
      for (int i = 0; i < N_SRC; i++) begin
         new_score = score_in[i*SCORE_W +: SCORE_W];
         if (alert_valid_in[i] && !guardian_enable[i]) begin
            // Source is in holdoff: alert is dropped but accounted for.
            events = events + 9'd1;
         end else if (enable && alert_valid_in[i]) begin
            if (!pend_q[i]) begin
               pend_d[i]  = 1'b1;
               score_d[i] = new_score;
               id_d[i]    = block_id_in[i*ID_W +: ID_W];
            end else begin
               // Merge: strictly higher score wins, ties keep the stored entry.
               events = events + 9'd1;
               if (new_score > score_q[i]) begin
                  score_d[i] = new_score;
                  id_d[i]    = block_id_in[i*ID_W +: ID_W];
               end
            end
         end
         // A merge into the granted entry on its acceptance cycle is not re-queued.
         if (accept && (out_src_idx == IDX_W'(i))) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // Holdoff counters: reload on acceptance, otherwise count down to zero.
   always_comb begin
      ge_d = '0;
      for (int i = 0; i < N_SRC; i++) begin
         hold_d[i] = hold_q[i];
         if (accept && (out_src_idx == IDX_W'(i))) begin
            hold_d[i] = HO_LOAD;
         end else if (hold_q[i] != '0) begin
            hold_d[i] = hold_q[i] - 1'b1;
         end
         ge_d[i] = (hold_d[i] == '0);
      end
   end

   // Round-robin pick: first pending source at or after rr_ptr, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand_idx  = '0;
      // Scan downward so the last hit written is the nearest one to rr_ptr.
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand_idx = IDX_W'((int'(rr_ptr) + k) % N_SRC);
         if (pend_q[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   // Saturating accumulation of this cycle's merge/drop events.
   always_comb begin
      cnt_sum = {1'b0, coalesce_cnt} + events;
   end

   // FSM next-state and handshake decode.
   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      accept    = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && (pend_q != '0)) begin
               state_d = SEL;
            end
         end
         SEL: begin
            if (enable && sel_found) begin
               load_out = 1'b1;
               state_d  = PRESENT;
            end else begin
               state_d  = IDLE;
            end
         end
         PRESENT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               accept  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q          <= '0;
         rr_ptr          <= '0;
         guardian_enable <= '1;
         out_score       <= '0;
         out_block_id    <= '0;
         out_src_idx     <= '0;
         coalesce_cnt    <= '0;
         for (int i = 0; i < N_SRC; i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         pend_q          <= pend_d;
         guardian_enable <= ge_d;
         hold_q          <= hold_d;
         coalesce_cnt    <= (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];
         if (load_out) begin
            out_score    <= score_q[sel_idx];
            out_block_id <= id_q[sel_idx];
            out_src_idx  <= sel_idx;
         end
         if (accept) begin
            rr_ptr <= (out_src_idx == LAST_IDX) ? '0 : out_src_idx + 1'b1;
         end
      end
   end

   // Alert payload storage.
   always_ff @(posedge clk) begin
      // NOTE: payload storage has no reset; pend_q qualifies every read, so stale contents are never used.
      score_q <= score_d;
      id_q    <= id_d;
   end

endmodule
